// File: rtl/comp_serie_izq_der.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Optional build macro EARLY_EXIT_EN: finish as soon as the first differing bit is seen.
module comp_serie_izq_der #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [N:0] a_p,
  input  logic [N:0] b_p,
  output logic       busy,
  output logic       done,
  output logic [1:0] x_st,
  output logic       Z,
  output logic       eq
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] X_EQ = 2'b00;
  localparam logic [1:0] X_GT = 2'b01;
  localparam logic [1:0] X_LT = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      a_q, a_d, b_q, b_d;
  logic [1:0]      x_q, x_d;
  logic            z_q, z_d, eq_q, eq_d;
  logic            last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CW'(N);
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= X_EQ;
      z_q     <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      z_q     <= z_d;
      eq_q    <= eq_d;
    end
  end

  // Operands shift left each RUN cycle so the bit under test is always at [N].
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    z_d      = z_q;
    eq_d     = eq_q;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_p;
          b_d     = b_p;
          cnt_d   = CW'(N);
          x_d     = X_EQ;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d = a_q << 1;
        b_d = b_q << 1;
        if (x_q == X_EQ) begin
          if (a_q[N] && !b_q[N])      x_d = X_GT;
          else if (!a_q[N] && b_q[N]) x_d = X_LT;
        end
        last_bit = (cnt_q == '0);
`ifdef EARLY_EXIT_EN
        if (x_q == X_EQ && x_d != X_EQ) last_bit = 1'b1;
`endif
        if (last_bit) begin
          state_d = DONE;
          z_d     = (x_d == X_GT);
          eq_d    = (x_d == X_EQ);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign x_st = x_q;
  assign Z    = z_q;
  assign eq   = eq_q;

endmodule
